// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_cmd_sequencer
// Purpose : FIFO-buffered {op,a,b} issue onto a combinational ALU with a
//           registered, valid/ready result. Optional macro: ALU_SEQ_BYPASS_EN
//           (empty-FIFO commands issue directly in the cycle they arrive).
// Revision: 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [7:0]       cmd_a_i,
  input  logic [7:0]       cmd_b_i,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [2:0]       alu_op_o,
  input  logic [7:0]       alu_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [7:0]       res_data_o,
  output logic             res_zero_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 3 + 8 + 8;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               res_valid_q, res_valid_d;
  logic [7:0]         res_data_q, res_data_d;

  logic               empty;
  logic               slot_free;
  logic               push;
  logic               push_fifo;
  logic               issue_fifo;
  logic               bypass;
  logic               issue;
  logic [ENTRY_W-1:0] head;

  assign empty       = (count_q == '0);
  assign cmd_ready_o = (count_q != CNT_W'(DEPTH));
  assign slot_free   = !res_valid_q || res_ready_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign issue_fifo  = !empty && slot_free;
  assign head        = mem_q[rd_ptr_q];

`ifdef ALU_SEQ_BYPASS_EN
  // Only an empty FIFO may be bypassed, so ordering is preserved.
  assign bypass = empty && slot_free && cmd_valid_i;
`else
  assign bypass = 1'b0;
`endif

  assign push_fifo = push && !bypass;
  assign issue     = issue_fifo || bypass;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    if (push_fifo) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (issue_fifo) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_fifo, issue_fifo})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_res_i;
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_comb begin
    alu_op_o = 3'd0;
    alu_a_o  = 8'd0;
    alu_b_o  = 8'd0;
    if (!empty) begin
      {alu_op_o, alu_a_o, alu_b_o} = head;
    end else if (bypass) begin
      {alu_op_o, alu_a_o, alu_b_o} = {cmd_op_i, cmd_a_i, cmd_b_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      mem_q[wr_ptr_q] <= {cmd_op_i, cmd_a_i, cmd_b_i};
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_zero_o  = (res_data_q == 8'h00);
  assign count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_cmd_sequencer
// Purpose : Scoreboard bench for alu_cmd_sequencer with a behavioural ALU.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ALU_SEQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_op;
  logic [7:0]       alu_res;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_zero;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  logic [7:0] exp_q [$];

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_a_i    (cmd_a),
    .cmd_b_i    (cmd_b),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_op_o   (alu_op),
    .alu_res_i  (alu_res),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_data_o (res_data),
    .res_zero_o (res_zero),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_res = ref_alu(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  // Input side: an accepted command's expected result enters the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!reset && cmd_valid && cmd_ready) begin
      exp_q.push_back(ref_alu(cmd_op, cmd_a, cmd_b));
      n_acc++;
    end
  end

  // Output side: every consumed result is checked in order.
  initial forever begin
    @(negedge clk);
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_data), 32'hDEAD);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("sb_data", 32'(res_data), 32'(e));
        chk("sb_zero", 32'(res_zero), 32'(e == 8'h00));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int cyc;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 8'd0;
    cmd_b     = 8'd0;
    res_ready = 1'b1;
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_alu", {13'd0, alu_op, alu_a, alu_b}, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    step();

    // Single-command latency
    drive(3'd0, 8'h12, 8'h34);
    step();
    cmd_valid = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      if (e < LAT) begin
        chk("lat_early_valid", 32'(res_valid), 0);
        step();
      end else begin
        chk("lat_valid", 32'(res_valid), 1);
        chk("lat_data", 32'(res_data), 32'h46);
        chk("lat_zero", 32'(res_zero), 0);
      end
    end
    repeat (3) step();

    // Back-pressure fill, then full-FIFO push attempt while popping
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      step();
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_ready", 32'(cmd_ready), 0);
    chk("fill_valid", 32'(res_valid), 1);
    drive(3'd2, 8'hA5, 8'h5A);
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("full_pop_count", 32'(count), 3);
    for (int i = 0; i < 4; i++) begin
      chk("drain_consecutive", 32'(res_valid), 1);
      step();
    end
    chk("drain_done", 32'(res_valid), 0);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);

    // Zero flag and 8-bit wrap
    res_ready = 1'b0;
    drive(3'd1, 8'h05, 8'h05);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("zero_valid", 32'(res_valid), 1);
    chk("zero_data", 32'(res_data), 0);
    chk("zero_flag", 32'(res_zero), 1);
    drive(3'd0, 8'hFF, 8'h02);
    step();
    cmd_valid = 1'b0;
    step();
    res_ready = 1'b1;
    step();
    chk("wrap_valid", 32'(res_valid), 1);
    chk("wrap_data", 32'(res_data), 32'h01);
    chk("wrap_zero", 32'(res_zero), 0);
    repeat (3) step();

    // Random stream with random result stalls
    start = n_acc;
    cyc   = 0;
    while ((n_acc - start) < 20 && cyc < 600) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      res_ready = ($urandom_range(0, 2) == 0);
      step();
      cyc++;
    end
    cmd_valid = 1'b0;
    chk("stream_accepted", 32'(n_acc - start), 20);
    res_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    step();
    chk("stream_drained", 32'(exp_q.size()), 0);
    chk("stream_count", 32'(count), 0);

    // Reset with work in flight
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      step();
    end
    cmd_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_valid", 32'(res_valid), 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(res_valid), 0);
    chk("async_rst_data", 32'(res_data), 0);
    chk("async_rst_alu", {13'd0, alu_op, alu_a, alu_b}, 0);
    step();
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    res_ready = 1'b1;
    drive(3'd2, 8'hC3, 8'h0F);
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("post_rst_drained", 32'(exp_q.size()), 0);
    chk("post_rst_data", 32'(res_data), 32'hCC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
